// File: rtl/mac_pkg.sv
// -----------------------------------------------------------------------------
// mac_pkg
// Definitions shared by the MAC-side arithmetic blocks. The sequential divider
// uses three of them:
//   DIV_WIDTH   : default operand/result width
//   div_state_e : divider FSM state encoding (IDLE/CALC/FIX)
//   abs_val     : two's-complement magnitude, used by the signed build
// No ports (package).
// -----------------------------------------------------------------------------
package mac_pkg;

   localparam int DIV_WIDTH = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_FIX  = 2'd2
   } div_state_e;

   // The result is read as unsigned. The most negative value therefore maps to
   // its true magnitude (e.g. 0x80 -> 128 at 8 bits).
   function automatic logic [DIV_WIDTH-1:0] abs_val(input logic [DIV_WIDTH-1:0] x);
      return x[DIV_WIDTH-1] ? (~x + DIV_WIDTH'(1)) : x;
   endfunction

endpackage

// File: rtl/seq_divider_if.sv
// -----------------------------------------------------------------------------
// seq_divider_if
// Groups the divider's request and result signals into one bundle.
// Handshake: the divider accepts a request on a rising edge where start=1 and
// busy=0. It captures dividend/divisor on that edge. A start seen while busy=1
// is dropped. done pulses for one cycle when a result is written.
// quotient/remainder/div_by_zero/overflow then hold until the next result.
// Signals:
//   start, dividend, divisor            requester -> divider
//   busy, done, quotient, remainder,
//   div_by_zero, overflow               divider -> requester
//   state                               divider FSM state (debug observation)
// Modports: master (requester side), slave (divider side).
// -----------------------------------------------------------------------------
interface seq_divider_if
   import mac_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
);
   logic             start;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             div_by_zero;
   logic             overflow;
   logic [1:0]       state;

   modport master (
      output start, dividend, divisor,
      input  busy, done, quotient, remainder, div_by_zero, overflow, state
   );

   modport slave (
      input  start, dividend, divisor,
      output busy, done, quotient, remainder, div_by_zero, overflow, state
   );

endinterface

// File: rtl/seq_divider_div_step.sv
// -----------------------------------------------------------------------------
// div_step
// Combinational logic for one restoring-division iteration. The block shifts
// the partial remainder left and brings in the next dividend bit. It then
// subtracts the divisor if the shifted value is large enough.
// Ports:
//   p_i     [WIDTH:0]   partial remainder before the step
//   d_i     [WIDTH-1:0] divisor magnitude
//   bit_i               next dividend bit (MSB first)
//   p_o     [WIDTH:0]   partial remainder after the step
//   q_bit_o             quotient bit produced by this step
// -----------------------------------------------------------------------------
module div_step
   import mac_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic [WIDTH:0]   p_i,
   input  logic [WIDTH-1:0] d_i,
   input  logic             bit_i,
   output logic [WIDTH:0]   p_o,
   output logic             q_bit_o
);

   // The shift goes into a one-bit-wider value so that no bit is lost.
   // Because P < D holds between steps, the wider value always fits back
   // into WIDTH+1 bits.
   logic [WIDTH+1:0] shifted;
   logic [WIDTH+1:0] diff;
   logic             ge;

   assign shifted = {p_i, bit_i};
   assign ge      = (shifted >= {2'b00, d_i});
   assign diff    = shifted - {2'b00, d_i};

   assign q_bit_o = ge;
   assign p_o     = ge ? (WIDTH+1)'(diff) : (WIDTH+1)'(shifted);

endmodule

// File: rtl/seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider
// Iterative restoring divider that produces one quotient bit per clock.
// A start accepted in IDLE loads the operand magnitudes. CALC then runs WIDTH
// iterations, and FIX writes the result and pulses done. A zero divisor skips
// CALC and goes straight to FIX, so done follows one edge after acceptance.
// Otherwise done follows WIDTH+1 edges after acceptance.
// Build option: define SEQ_DIV_SIGNED_EN for two's-complement operands.
// The core still divides magnitudes. The quotient is truncated toward zero,
// and the remainder takes the dividend's sign. MIN/-1 raises overflow.
// Without the macro, operands are unsigned and overflow stays 0.
// Ports:
//   clk     rising-edge clock
//   rst_n   synchronous active-low reset (aborts any operation, clears outputs)
//   bus     seq_divider_if.slave: start/dividend/divisor in;
//           busy/done/quotient/remainder/div_by_zero/overflow/state out
// -----------------------------------------------------------------------------
module seq_divider
   import mac_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic            clk,
   input  logic            rst_n,
   seq_divider_if.slave    bus
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   localparam logic [1:0] S_IDLE = 2'(ST_IDLE);
   localparam logic [1:0] S_CALC = 2'(ST_CALC);
   localparam logic [1:0] S_FIX  = 2'(ST_FIX);

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q,   cnt_d;
   logic [WIDTH:0]   p_q,     p_d;     // partial remainder
   logic [WIDTH-1:0] a_q,     a_d;     // dividend bits shift out, quotient bits shift in
   logic [WIDTH-1:0] d_q,     d_d;     // divisor magnitude
   logic [WIDTH-1:0] dvd_q,   dvd_d;   // raw dividend (remainder on divide-by-zero, sign)
   logic             zero_q,  zero_d;  // current operation is a divide-by-zero
`ifdef SEQ_DIV_SIGNED_EN
   logic [WIDTH-1:0] dvs_q,   dvs_d;   // raw divisor, kept for sign and MIN/-1
`endif

   logic [WIDTH-1:0] quo_q,   quo_d;
   logic [WIDTH-1:0] rem_q,   rem_d;
   logic             done_q,  done_d;
   logic             dbz_q,   dbz_d;
   logic             ovf_q,   ovf_d;

   logic [WIDTH:0]   step_p;
   logic             step_q;

   div_step #(.WIDTH(WIDTH)) u_step (
      .p_i     (p_q),
      .d_i     (d_q),
      .bit_i   (a_q[WIDTH-1]),
      .p_o     (step_p),
      .q_bit_o (step_q)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      p_d     = p_q;
      a_d     = a_q;
      d_d     = d_q;
      dvd_d   = dvd_q;
      zero_d  = zero_q;
`ifdef SEQ_DIV_SIGNED_EN
      dvs_d   = dvs_q;
`endif
      quo_d   = quo_q;
      rem_d   = rem_q;
      done_d  = 1'b0;
      dbz_d   = dbz_q;
      ovf_d   = ovf_q;

      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               dvd_d = bus.dividend;
`ifdef SEQ_DIV_SIGNED_EN
               dvs_d = bus.divisor;
`endif
               if (bus.divisor == '0) begin
                  zero_d  = 1'b1;
                  state_d = S_FIX;
               end else begin
                  zero_d  = 1'b0;
                  p_d     = '0;
                  cnt_d   = CNT_W'(WIDTH - 1);
                  state_d = S_CALC;
`ifdef SEQ_DIV_SIGNED_EN
                  // abs_val is DIV_WIDTH wide; the signed build assumes WIDTH == DIV_WIDTH.
                  a_d = WIDTH'(abs_val(DIV_WIDTH'(bus.dividend)));
                  d_d = WIDTH'(abs_val(DIV_WIDTH'(bus.divisor)));
`else
                  a_d = bus.dividend;
                  d_d = bus.divisor;
`endif
               end
            end
         end

         S_CALC: begin
            p_d = step_p;
            a_d = {a_q[WIDTH-2:0], step_q};
            if (cnt_q == '0) state_d = S_FIX;
            else             cnt_d   = cnt_q - CNT_W'(1);
         end

         S_FIX: begin
            done_d  = 1'b1;
            state_d = S_IDLE;
            if (zero_q) begin
               quo_d = '1;
               rem_d = dvd_q;
               dbz_d = 1'b1;
               ovf_d = 1'b0;
            end else begin
               dbz_d = 1'b0;
`ifdef SEQ_DIV_SIGNED_EN
               // MIN/-1 needs no special result: magnitude 2^(W-1) with a
               // positive sign already reads back as MIN. Only the flag is extra.
               quo_d = (dvd_q[WIDTH-1] ^ dvs_q[WIDTH-1]) ? (~a_q + WIDTH'(1)) : a_q;
               rem_d = dvd_q[WIDTH-1] ? (~p_q[WIDTH-1:0] + WIDTH'(1)) : p_q[WIDTH-1:0];
               ovf_d = (dvd_q == {1'b1, {(WIDTH-1){1'b0}}}) && (dvs_q == '1);
`else
               quo_d = a_q;
               rem_d = p_q[WIDTH-1:0];
               ovf_d = 1'b0;
`endif
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         p_q     <= '0;
         a_q     <= '0;
         d_q     <= '0;
         dvd_q   <= '0;
         zero_q  <= 1'b0;
`ifdef SEQ_DIV_SIGNED_EN
         dvs_q   <= '0;
`endif
         quo_q   <= '0;
         rem_q   <= '0;
         done_q  <= 1'b0;
         dbz_q   <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         p_q     <= p_d;
         a_q     <= a_d;
         d_q     <= d_d;
         dvd_q   <= dvd_d;
         zero_q  <= zero_d;
`ifdef SEQ_DIV_SIGNED_EN
         dvs_q   <= dvs_d;
`endif
         quo_q   <= quo_d;
         rem_q   <= rem_d;
         done_q  <= done_d;
         dbz_q   <= dbz_d;
         ovf_q   <= ovf_d;
      end
   end

   assign bus.busy        = (state_q != S_IDLE);
   assign bus.done        = done_q;
   assign bus.quotient    = quo_q;
   assign bus.remainder   = rem_q;
   assign bus.div_by_zero = dbz_q;
   assign bus.overflow    = ovf_q;
   assign bus.state       = state_q;

endmodule
